univ_shift_reg: RTL

UNIV_SHIFT_REG -- requirements
Module: univ_shift_reg

---
 rtl/univ_shift_pkg.sv | 28 ++
 rtl/univ_shift_step.sv | 46 ++++
 rtl/univ_shift_reg.sv | 122 ++++++++++++
 3 files changed

// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation codes and FSM states.
package univ_shift_pkg;

  typedef enum logic [2:0] {
    OP_LOAD = 3'b000,
    OP_SHL  = 3'b001,
    OP_SHR  = 3'b010,
    OP_ROL  = 3'b011,
    OP_ROR  = 3'b100,
    OP_ASR  = 3'b101,
    OP_RSV6 = 3'b110,
    OP_RSV7 = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  localparam op_e OP_RSV_A = OP_RSV6;
  localparam op_e OP_RSV_B = OP_RSV7;

  function automatic logic is_reserved(input op_e o);
    return (o == OP_RSV_A) || (o == OP_RSV_B);
  endfunction

endpackage

// File: rtl/univ_shift_step.sv
// Combinational single-step shifter: one shift/rotate of q plus the bit that leaves.
module univ_shift_step
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] q,
  input  op_e              op,
  input  logic             sin_l,
  input  logic             sin_r,
  output logic [WIDTH-1:0] q_next,
  output logic             out_bit
);

  always_comb begin
    q_next  = q;
    out_bit = 1'b0;
    case (op)
      OP_SHL: begin
        q_next  = {q[WIDTH-2:0], sin_r};
        out_bit = q[WIDTH-1];
      end
      OP_SHR: begin
        q_next  = {sin_l, q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ROL: begin
        q_next  = {q[WIDTH-2:0], q[WIDTH-1]};
        out_bit = q[WIDTH-1];
      end
      OP_ROR: begin
        q_next  = {q[0], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      OP_ASR: begin
        q_next  = {q[WIDTH-1], q[WIDTH-1:1]};
        out_bit = q[0];
      end
      default: begin
        q_next  = q;
        out_bit = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register: LOAD / shift / rotate / arithmetic shift by a counted
// number of single-bit steps, with abort and a one-cycle done pulse.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             sin_l,
  input  logic             sin_r,
  input  logic             abort,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             so_q, so_d;

  op_e              op_in;
  logic [CNT_W-1:0] amt_sat;
  logic             go_shift;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign op_in    = op_e'(op);
  assign amt_sat  = (amount > WIDTH_C) ? WIDTH_C : amount;
  assign go_shift = (op_in != OP_LOAD) && !is_reserved(op_in) && (amt_sat != '0);

  univ_shift_step #(.WIDTH(WIDTH)) u_step (
    .q       (q_q),
    .op      (op_q),
    .sin_l   (sin_l),
    .sin_r   (sin_r),
    .q_next  (step_q),
    .out_bit (step_out)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = go_shift ? ST_SHIFT : ST_DONE;
      ST_SHIFT: begin
        if (abort)                 state_d = ST_IDLE;
        else if (cnt_q == CNT_ONE) state_d = ST_DONE;
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    done = (state_q == ST_DONE);
  end

  // Datapath: op/amount captured at the accepting edge, one step per SHIFT cycle.
  always_comb begin
    op_d  = op_q;
    cnt_d = cnt_q;
    q_d   = q_q;
    so_d  = so_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d  = op_in;
          cnt_d = go_shift ? amt_sat : '0;
          if (op_in == OP_LOAD) q_d = load_data;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          cnt_d = '0;
        end else begin
          q_d   = step_q;
          so_d  = step_out;
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      op_q  <= OP_LOAD;
      cnt_q <= '0;
      q_q   <= '0;
      so_q  <= 1'b0;
    end else begin
      op_q  <= op_d;
      cnt_q <= cnt_d;
      q_q   <= q_d;
      so_q  <= so_d;
    end
  end

  assign q         = q_q;
  assign shift_out = so_q;

endmodule
